muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative integer multiply / divide unit (RV32M op set).
//
// Multiplies use a 32-step shift-add and divides a 32-step restoring divide.
// Both work on operand magnitudes, and the sign is applied to the final value.
// Division by zero and the signed overflow case (0x80000000 / -1) bypass the
// iteration and complete on the cycle after accept.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> multiply ops are computed combinationally and complete on the
//                cycle after accept (busy never asserted).
//   undefined -> multiply ops iterate for 32 cycles, exactly like divides.
//
// Handshake: a request is taken on a rising edge where start=1 and the unit is
// ready (state IDLE or DONE) and flush=0. The result is valid while done=1
// (a one-cycle pulse) and stays on `result` until the next accepted start.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request strobe (sampled only when ready)
//   op      in   [2:0] MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   a       in   [31:0] rs1 (multiplicand / dividend)
//   b       in   [31:0] rs2 (multiplier / divisor)
//   flush   in   synchronous abort, wins over start
//   busy    out  high while iterating (state CALC)
//   done    out  one-cycle result-valid pulse (state DONE)
//   result  out  [31:0] last result
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;     // final value must be negated
    logic [31:0] m_q, m_d;         // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [31:0] result_q, result_d;

    logic        ready, accept;
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        b_zero, div_ovf;
    logic [32:0] mul_sum, div_part, div_diff;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] calc_res;

    assign ready  = (state_q != S_CALC);
    assign accept = start && ready && !flush;

    // Signedness of each operand by op: MULH, MULHSU, DIV, REM treat a as signed;
    // MULH, DIV, REM treat b as signed.
    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign a_neg    = a_signed && a[31];
    assign b_neg    = b_signed && b[31];
    assign a_mag    = a_neg ? (32'd0 - a) : a;
    assign b_mag    = b_neg ? (32'd0 - b) : b;
    assign b_zero   = (b == 32'd0);
    assign div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                      (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // One iteration of the datapath, chosen by the latched op.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        div_part = {acc_q[63:32], acc_q[31]};
        // Partial remainder is always < 2*divisor, so a clear bit 32 means it fits.
        div_diff = div_part - {1'b0, m_q};
        step_acc = {mul_sum, acc_q[31:1]};
        if (op_q[2]) begin
            if (!div_diff[32]) begin
                step_acc = {div_diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                step_acc = {div_part[31:0], acc_q[30:0], 1'b0};
            end
        end
    end

    // Sign correction and selection of the final value from the last step.
    always_comb begin
        prod_fix = neg_q ? (64'd0 - step_acc) : step_acc;
        quo_fix  = neg_q ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
        rem_fix  = neg_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
        case (op_q)
            3'b000:         calc_res = prod_fix[31:0];
            3'b001, 3'b010,
            3'b011:         calc_res = prod_fix[63:32];
            3'b100, 3'b101: calc_res = quo_fix;
            default:        calc_res = rem_fix;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_a, fast_b;
    logic        [63:0] fast_prod;
    logic        [31:0] fast_res;

    always_comb begin
        fast_a    = {{32{a_neg}}, a};
        fast_b    = {{32{b_neg}}, b};
        fast_prod = fast_a * fast_b;
        fast_res  = (op == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        m_d      = m_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        cnt_d    = 5'd0;
                        result_d = calc_res;
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        op_d  = op;
                        cnt_d = 5'd0;
                        if (op[2]) begin
                            m_d   = b_mag;
                            acc_d = {32'd0, a_mag};
                            // Remainder follows the dividend; quotient the sign XOR.
                            neg_d = op[1] ? a_neg : (a_neg ^ b_neg);
                        end else begin
                            m_d   = a_mag;
                            acc_d = {32'd0, b_mag};
                            neg_d = a_neg ^ b_neg;
                        end
                        if (op[2] && b_zero) begin
                            state_d  = S_DONE;
                            result_d = op[1] ? a : 32'hFFFF_FFFF;
                        end else if (op[2] && div_ovf) begin
                            state_d  = S_DONE;
                            result_d = op[1] ? 32'd0 : 32'h8000_0000;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!op[2]) begin
                            state_d  = S_DONE;
                            result_d = fast_res;
                        end
`endif
                        else begin
                            state_d = S_CALC;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            m_q      <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_fail;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: called away from a rising edge; issues one request and waits for
    // done (bounded). lat = cycles after the accept edge at which done was seen.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bsy, output logic [31:0] res);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bsy = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        int lat, bsy;
        logic [31:0] res;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        // Request is driven together with reset release: must be taken on the first edge.
        @(negedge clk);
        rst_n = 1'b1;
        do_op(OP_DIVU, 32'd9, 32'd3, lat, bsy, res);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL first_edge_lat got=%0d exp=33", lat); end
        n_cmp++; if (res !== 32'd3) begin n_fail++; $display("FAIL first_edge_res got=%h exp=3", res); end
    endtask

    task automatic test_divu();
        int lat, bsy;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_DIVU, 32'd100, 32'd7, lat, bsy, res);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL divu_lat got=%0d exp=33", lat); end
        n_cmp++; if (bsy !== 32) begin n_fail++; $display("FAIL divu_busy got=%0d exp=32", bsy); end
        n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_res got=%h exp=e", res); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%b exp=0", done); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL result_hold got=%h exp=e", result); end
        @(negedge clk);
        do_op(OP_REMU, 32'd100, 32'd7, lat, bsy, res);
        n_cmp++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_res got=%h exp=2", res); end
    endtask

    task automatic test_signed_div();
        int lat, bsy;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg got=%h exp=fffffffd", res); end
        @(negedge clk);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg got=%h exp=ffffffff", res); end
        @(negedge clk);
        do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, bsy, res);
        n_cmp++; if (res !== 32'd1) begin n_fail++; $display("FAIL rem_pos_div_neg got=%h exp=1", res); end
    endtask

    task automatic test_div_special();
        int lat, bsy;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_DIV, 32'd5, 32'd0, lat, bsy, res);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divz_lat got=%0d exp=1", lat); end
        n_cmp++; if (bsy !== 0) begin n_fail++; $display("FAIL divz_busy got=%0d exp=0", bsy); end
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_res got=%h exp=ffffffff", res); end
        @(negedge clk);
        do_op(OP_REMU, 32'd5, 32'd0, lat, bsy, res);
        n_cmp++; if (res !== 32'd5) begin n_fail++; $display("FAIL remuz_res got=%h exp=5", res); end
        @(negedge clk);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ovf_lat got=%0d exp=1", lat); end
        n_cmp++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_div got=%h exp=80000000", res); end
        @(negedge clk);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (res !== 32'd0) begin n_fail++; $display("FAIL ovf_rem got=%h exp=0", res); end
    endtask

    task automatic test_mul();
        int lat, bsy;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (res !== 32'd0) begin n_fail++; $display("FAIL mulh got=%h exp=0", res); end
        n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_lat got=%0d exp=%0d", lat, MUL_LAT); end
        n_cmp++; if (bsy !== MUL_BUSY) begin n_fail++; $display("FAIL mul_busy got=%0d exp=%0d", bsy, MUL_BUSY); end
        @(negedge clk);
        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
        @(negedge clk);
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (res !== 32'd1) begin n_fail++; $display("FAIL mul_ff got=%h exp=1", res); end
        @(negedge clk);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
        @(negedge clk);
        do_op(OP_MUL, 32'd12345, 32'd678, lat, bsy, res);
        n_cmp++; if (res !== 32'h007F_B6F6) begin n_fail++; $display("FAIL mul_small got=%h exp=7fb6f6", res); end
        @(negedge clk);
        do_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg got=%h exp=ffffffff", res); end
        @(negedge clk);
        do_op(OP_MULHU, 32'hFFFF_FFFE, 32'd3, lat, bsy, res);
        n_cmp++; if (res !== 32'd2) begin n_fail++; $display("FAIL mulhu_small got=%h exp=2", res); end
    endtask

    task automatic test_flush();
        int lat, bsy, bad;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_DIVU, 32'd100, 32'd7, lat, bsy, res);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", busy); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result got=%h exp=e", result); end
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", bad); end
        // flush and start together: request must be dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_prio got=%b%b exp=00", busy, done); end
        @(negedge clk);
        do_op(OP_DIVU, 32'd9, 32'd3, lat, bsy, res);
        n_cmp++; if (res !== 32'd3) begin n_fail++; $display("FAIL after_flush got=%h exp=3", res); end
    endtask

    task automatic test_reset_mid_calc();
        int bad;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%b%b exp=00", busy, done); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL async_rst_res got=%h exp=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", bad); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        // keep start high with different operands for the whole CALC phase
        op = OP_MUL; a = 32'd9; b = 32'd3;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_lat got=%0d exp=33", lat); end
        n_cmp++; if (result !== 32'd14) begin n_fail++; $display("FAIL ignore_res got=%h exp=e", result); end
    endtask

    task automatic test_back_to_back();
        int lat, bsy;
        logic [31:0] res;
        @(negedge clk);
        do_op(OP_DIV, 32'd5, 32'd0, lat, bsy, res);
        // issue the next request while the previous one is in DONE
        do_op(OP_DIVU, 32'd1000, 32'd10, lat, bsy, res);
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
        n_cmp++; if (res !== 32'd100) begin n_fail++; $display("FAIL b2b_res got=%h exp=64", res); end
        do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, lat, bsy, res);
        n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_rem got=%h exp=fffffffe", res); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        test_reset();
        test_divu();
        test_signed_div();
        test_div_special();
        test_mul();
        test_flush();
        test_reset_mid_calc();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
